// File: rtl/setpoint_ramp_scheduler_pkg.sv
// setpoint_ramp_scheduler_pkg: shared width, clamp defaults and FSM encoding
package setpoint_ramp_scheduler_pkg;
   localparam int N = 18;
   localparam int REF_MAX_DEF = 131071;
   localparam int REF_MIN_DEF = -131072;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAMP   = 2'd1,
      SETTLE = 2'd2
   } state_t;
endpackage

// File: rtl/setpoint_ramp_scheduler_if.sv
// setpoint_ramp_scheduler_if: command/reference bundle between sequencer and control loop
interface setpoint_ramp_scheduler_if #(parameter int W = 18) ();
   logic                tick;
   logic                load;
   logic                hold;
   logic signed [W-1:0] target;
   logic [W-2:0]        step;
   logic signed [W-1:0] ref_value;
   logic                ref_strobe;
   logic                busy;
   logic                done;
   modport master (output tick, load, hold, target, step, input ref_value, ref_strobe, busy, done);
   modport slave (input tick, load, hold, target, step, output ref_value, ref_strobe, busy, done);
endinterface

// File: rtl/setpoint_ramp_scheduler_ramp_step_calc.sv
// ramp_step_calc: one ramp step toward the target, widened by one bit so nothing wraps
module ramp_step_calc
   import setpoint_ramp_scheduler_pkg::*;
#(
   parameter int W       = N,
   parameter int REF_MAX = REF_MAX_DEF,
   parameter int REF_MIN = REF_MIN_DEF
) (
   input  logic signed [W-1:0] ref_value,
   input  logic signed [W-1:0] tgt_q,
   input  logic [W-2:0]        step,
   output logic signed [W-1:0] next_ref,
   output logic                arrived
);
   localparam logic signed [W:0] HI = REF_MAX[W:0];
   localparam logic signed [W:0] LO = REF_MIN[W:0];
   logic signed [W:0] diff, sum;
   logic [W:0] mag;
   // difference, arrival test and clamped step in W+1 bits
   always_comb begin
      diff = {tgt_q[W-1], tgt_q} - {ref_value[W-1], ref_value};
      mag = diff[W] ? -diff : diff;
      arrived = (step == '0) || (mag <= {2'b00, step});
      sum = diff[W] ? {ref_value[W-1], ref_value} - {2'b00, step} : {ref_value[W-1], ref_value} + {2'b00, step};
      next_ref = arrived ? tgt_q : (sum > HI) ? HI[W-1:0] : (sum < LO) ? LO[W-1:0] : sum[W-1:0];
   end
endmodule

// File: rtl/setpoint_ramp_scheduler.sv
// setpoint_ramp_scheduler: ramps the applied setpoint toward a loaded target on sample ticks
module setpoint_ramp_scheduler
   import setpoint_ramp_scheduler_pkg::*;
#(
   parameter int W            = N,
   parameter int REF_MAX      = REF_MAX_DEF,
   parameter int REF_MIN      = REF_MIN_DEF,
   parameter int SETTLE_TICKS = 8
) (
   input logic                      clk,
   input logic                      reset,
   setpoint_ramp_scheduler_if.slave sp
);
   localparam logic signed [W:0] HI = REF_MAX[W:0];
   localparam logic signed [W:0] LO = REF_MIN[W:0];
   localparam logic [7:0] ST = SETTLE_TICKS[7:0];
   state_t state, state_n;
   logic signed [W-1:0] tgt_q, ref_q, tgt_c, next_ref;
   logic signed [W:0] tx;
   logic [7:0] dwell;
   logic arrived, adv, settle_end, busy_n, done_n, busy_q, done_q, strobe_q;
   assign tx = {sp.target[W-1], sp.target};
   assign tgt_c = (tx > HI) ? HI[W-1:0] : (tx < LO) ? LO[W-1:0] : tx[W-1:0];
   assign adv = sp.tick && !sp.hold && !sp.load;
   assign settle_end = (dwell + 8'd1) == ST;
   assign sp.ref_value = ref_q;
   assign sp.ref_strobe = strobe_q;
   assign sp.busy = busy_q;
   assign sp.done = done_q;
   ramp_step_calc #(.W(W), .REF_MAX(REF_MAX), .REF_MIN(REF_MIN)) u_calc (
      .ref_value (ref_q),
      .tgt_q     (tgt_q),
      .step      (sp.step),
      .next_ref  (next_ref),
      .arrived   (arrived)
   );
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   // next state: load overrides any tick activity
   always_comb begin
      state_n = state;
      if (sp.load) state_n = (tgt_c != ref_q) ? RAMP : SETTLE;
      else if (adv && state == RAMP) state_n = arrived ? SETTLE : RAMP;
      else if (adv && state == SETTLE) state_n = settle_end ? IDLE : SETTLE;
   end
   // output decode, registered below
   always_comb begin
      busy_n = state_n != IDLE;
      done_n = adv && state == SETTLE && settle_end;
   end
   // target, reference, dwell and output registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tgt_q    <= '0;
         ref_q    <= '0;
         dwell    <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         strobe_q <= sp.tick;
         busy_q   <= busy_n;
         done_q   <= done_n;
         if (sp.load) begin
            tgt_q <= tgt_c;
            dwell <= '0;
         end else if (adv && state == RAMP) begin
            ref_q <= next_ref;
            dwell <= '0;
         end else if (adv && state == SETTLE) dwell <= settle_end ? '0 : dwell + 8'd1;
      end
endmodule

// File: tb/tb_setpoint_ramp_scheduler.sv
// tb_setpoint_ramp_scheduler: table-driven check of ramp, clamp, hold, settle and reset behaviour
module tb_setpoint_ramp_scheduler;
   typedef struct {
      logic l, t, h;
      logic signed [17:0] tgt;
      logic [16:0] stp;
      logic signed [17:0] eref;
      logic eb, ed;
   } vec_t;
   vec_t vq[$];
   int total = 0;
   int bad = 0;
   logic clk = 1'b0;
   logic reset = 1'b0;
   setpoint_ramp_scheduler_if #(.W(18)) sp ();
   setpoint_ramp_scheduler #(.W(18), .REF_MAX(1000), .REF_MIN(-1000), .SETTLE_TICKS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .sp    (sp)
   );
   always #5 clk = ~clk;
   task automatic add(input logic l, t, h, input int tgt, stp, eref, input logic eb, ed);
      vec_t v;
      v.l = l; v.t = t; v.h = h;
      v.tgt = tgt[17:0]; v.stp = stp[16:0]; v.eref = eref[17:0];
      v.eb = eb; v.ed = ed;
      vq.push_back(v);
   endtask
   task automatic ticks(input int n, tgt, stp, eref);
      for (int k = 0; k < n; k++) add(0, 1, 0, tgt, stp, eref, 1, 0);
   endtask
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic cyc(input logic l, t, h, input int tgt, stp);
      sp.load = l; sp.tick = t; sp.hold = h;
      sp.target = tgt[17:0]; sp.step = stp[16:0];
      @(posedge clk);
      #1;
      sp.load = 1'b0; sp.tick = 1'b0; sp.hold = 1'b0;
   endtask
   initial begin
      sp.load = 1'b0; sp.tick = 1'b0; sp.hold = 1'b0; sp.target = '0; sp.step = '0;
      // ramp up 0 -> 1000 by 300, settle 8 ticks, idle tick
      add(1, 0, 0, 1000, 300, 0, 1, 0);
      add(0, 1, 0, 1000, 300, 300, 1, 0);
      add(0, 0, 0, 1000, 300, 300, 1, 0);
      add(0, 1, 0, 1000, 300, 600, 1, 0);
      add(0, 1, 0, 1000, 300, 900, 1, 0);
      add(0, 1, 0, 1000, 300, 1000, 1, 0);
      ticks(7, 1000, 300, 1000);
      add(0, 1, 0, 1000, 300, 1000, 0, 1);
      add(0, 0, 0, 1000, 300, 1000, 0, 0);
      add(0, 1, 0, 1000, 300, 1000, 0, 0);
      // jump to 100, then ramp down to -256 by 128 with hold in RAMP and SETTLE
      add(1, 0, 0, 100, 0, 1000, 1, 0);
      add(0, 1, 0, 100, 0, 100, 1, 0);
      add(1, 0, 0, -256, 128, 100, 1, 0);
      add(0, 1, 0, -256, 128, -28, 1, 0);
      for (int k = 0; k < 3; k++) add(0, 1, 1, -256, 128, -28, 1, 0);
      add(0, 1, 0, -256, 128, -156, 1, 0);
      add(0, 1, 0, -256, 128, -256, 1, 0);
      ticks(7, -256, 128, -256);
      add(0, 1, 1, -256, 128, -256, 1, 0);
      add(0, 1, 1, -256, 128, -256, 1, 0);
      add(0, 1, 0, -256, 128, -256, 0, 1);
      // jumps with clamping at both rails; load on the cycle done would fire
      add(1, 0, 0, 5000, 0, -256, 1, 0);
      add(0, 1, 0, 5000, 0, 1000, 1, 0);
      add(1, 0, 0, -5000, 0, 1000, 1, 0);
      add(0, 1, 0, -5000, 0, -1000, 1, 0);
      ticks(7, -5000, 0, -1000);
      add(1, 1, 0, -1000, 0, -1000, 1, 0);
      ticks(7, -1000, 0, -1000);
      add(0, 1, 0, -1000, 0, -1000, 0, 1);
      // |diff| exactly equal to step arrives
      add(1, 0, 0, 0, 500, -1000, 1, 0);
      add(0, 1, 0, 0, 500, -500, 1, 0);
      add(0, 1, 0, 0, 500, 0, 1, 0);
      ticks(7, 0, 500, 0);
      add(0, 1, 0, 0, 500, 0, 0, 1);
      #12;
      chk("reset ref", int'(sp.ref_value), 0);
      chk("reset busy", int'(sp.busy), 0);
      chk("reset done", int'(sp.done), 0);
      chk("reset strobe", int'(sp.ref_strobe), 0);
      @(negedge clk);
      reset = 1'b1;
      foreach (vq[i]) begin
         cyc(vq[i].l, vq[i].t, vq[i].h, int'(vq[i].tgt), int'(vq[i].stp));
         chk($sformatf("v%0d ref", i), int'(sp.ref_value), int'(vq[i].eref));
         chk($sformatf("v%0d busy", i), int'(sp.busy), int'(vq[i].eb));
         chk($sformatf("v%0d done", i), int'(sp.done), int'(vq[i].ed));
         chk($sformatf("v%0d strobe", i), int'(sp.ref_strobe), int'(vq[i].t));
      end
      // retarget with load and tick colliding mid-ramp
      cyc(1, 0, 0, 1000, 100);
      repeat (4) cyc(0, 1, 0, 1000, 100);
      chk("retgt pre", int'(sp.ref_value), 400);
      cyc(1, 1, 0, 200, 100);
      chk("retgt hold ref", int'(sp.ref_value), 400);
      chk("retgt busy", int'(sp.busy), 1);
      chk("retgt strobe", int'(sp.ref_strobe), 1);
      cyc(0, 1, 0, 200, 100);
      chk("retgt 300", int'(sp.ref_value), 300);
      cyc(0, 1, 0, 200, 100);
      chk("retgt 200", int'(sp.ref_value), 200);
      // asynchronous reset in the middle of a ramp
      cyc(1, 0, 0, 1000, 100);
      repeat (3) cyc(0, 1, 0, 1000, 100);
      chk("arst pre", int'(sp.ref_value), 500);
      #2;
      reset = 1'b0;
      #1;
      chk("arst ref", int'(sp.ref_value), 0);
      chk("arst busy", int'(sp.busy), 0);
      chk("arst done", int'(sp.done), 0);
      chk("arst strobe", int'(sp.ref_strobe), 0);
      @(negedge clk);
      reset = 1'b1;
      cyc(0, 1, 0, 1000, 100);
      chk("idle tick ref", int'(sp.ref_value), 0);
      chk("idle tick busy", int'(sp.busy), 0);
      chk("idle tick strobe", int'(sp.ref_strobe), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
